uart_row_packet_rx: RTL and testbench
=====================================

Name: uart_row_packet_rx

Overview:
Parametrised packet framer between the uart_receiver byte stream and the VGA frame-buffer write port in the uart2vga design. Each packet is a Y coordinate (Y_BYTES, MSB first), ROW_BYTES pixel bytes and one STOP_BYTE. The block writes pixel bytes into the frame buffer as they arrive and returns one answer byte per packet through uart_transmiter. The previous fixed-format design had no bad-stop, out-of-range or inter-byte timeout handling; this block adds all three.

Parameters:
ROW_BYTES, 240, pixel bytes per packet (>=1)
Y_BYTES, 2, Y coordinate bytes per packet (1..4)
HEIGHT, 480, number of valid rows; Y >= HEIGHT is rejected
ADDR_WIDTH, 17, frame-buffer address width (>= clog2(HEIGHT*ROW_BYTES))
STOP_BYTE, 8'hDD, required terminator value
ACK_OK, 8'hFF, answer for a good packet (SUCCESSFULLY_RECEIVED)
ACK_FAIL, 8'h11, answer for a failed packet (NOT_ALL_RECEIVED)
TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between bytes inside a packet

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
en  in  1  receive enable; 0 drops incoming bytes while in WAIT_Y with y_cnt==0
rx_data  in  8  byte from uart_receiver
rx_done  in  1  one-cycle strobe, rx_data valid
tx_busy  in  1  uart_transmiter busy
tx_start  out  1  one-cycle start strobe to transmitter
tx_data  out  8  answer byte
fb_we  out  1  frame-buffer write enable
fb_addr  out  ADDR_WIDTH  write address = Y*ROW_BYTES + pixel index
fb_data  out  8  write data
row_done  out  1  one-cycle pulse on a good packet
row_y  out  16  Y of the last good packet
ok_cnt  out  8  good packets, saturating at 255
err_cnt  out  8  failed packets, saturating at 255

Behaviour:
- Reset (rst_n==0 at posedge clk): state=WAIT_Y; all outputs 0; y_cnt, pix_cnt and timer cleared. A reset during any state aborts the packet. No answer is sent for the aborted packet.
- States and transitions:
  - WAIT_Y: on each rx_done, shift rx_data into y_acc (y_acc = {y_acc[..], rx_data}) and increment y_cnt.
    - After Y_BYTES bytes, latch base = y_acc*ROW_BYTES (truncated to ADDR_WIDTH) and set y_bad = (y_acc >= HEIGHT). Go to WAIT_ROW.
  - WAIT_ROW: on each rx_done:
    - if !y_bad, in the next cycle fb_we=1, fb_addr=base+pix_cnt, fb_data=rx_data. Latency is 1 cycle from rx_done.
    - if y_bad, no write is issued.
    - pix_cnt increments; after ROW_BYTES bytes, go to WAIT_STOP.
  - WAIT_STOP: on rx_done:
    - if rx_data==STOP_BYTE and !y_bad: ans=ACK_OK.
    - otherwise: ans=ACK_FAIL.
    - Go to SEND_ACK.
  - SEND_ACK: when tx_busy==0, pulse tx_start for 1 cycle with tx_data=ans held stable, then go to WAIT_Y.
    - If tx_busy stays high, wait indefinitely.
    - On ACK_OK, pulse row_done in the same cycle as tx_start, set row_y=y_acc and increment ok_cnt.
    - On ACK_FAIL, increment err_cnt in the same cycle as tx_start.
- Timeout:
  - timer counts while in WAIT_Y with y_cnt>0, WAIT_ROW, or WAIT_STOP.
  - timer clears on every rx_done.
  - When timer reaches TIMEOUT_CYCLES-1 with no rx_done that cycle: ans=ACK_FAIL, go to SEND_ACK.
  - rx_done and timer expiry in the same cycle: the byte wins and the timer clears.
- Bytes arriving in SEND_ACK are ignored, not counted and not buffered.
- en==0 is sampled only at the first Y byte. A packet already in progress completes regardless of en.
- Frame-buffer writes already issued for a packet that later fails are not rolled back. Only row_done marks a valid row.
- Counters saturate at 255 and do not wrap.
- tx_start is never asserted while tx_busy==1.

Test Plan:
- Good packet: Y=0x0000, 240 random bytes, 0xDD -> 240 fb_we pulses at addresses 0..239 with matching data, each 1 cycle after rx_done; tx_start with tx_data=0xFF; row_done=1; row_y=0; ok_cnt=1.
- Row 479 bounds: Y=0x01DF, 240 bytes, 0xDD -> addresses 114960..115199; answer 0xFF. Y=0x01E0 -> zero fb_we pulses, answer 0x11, err_cnt=1.
- Bad stop: Y=5, 240 bytes, then 0xDC -> 240 writes at 1200..1439; answer 0x11; no row_done.
- Timeout: Y=3, 100 bytes, then silence -> TIMEOUT_CYCLES after the last rx_done, tx_start with 0x11. Next packet Y=4 (full, good) -> answer 0xFF, proving resync.
- Busy and reset: hold tx_busy=1 across the stop byte -> tx_start waits until the first cycle with tx_busy==0. Separately, assert rst_n=0 for 1 cycle mid-row -> all outputs 0, no answer sent, next full packet answered 0xFF.
- Edge timing: rx_done arriving exactly on the expiry cycle -> no timeout and the packet continues. Bytes sent during SEND_ACK are ignored (no writes, counts unchanged).

Source files
------------

// File: rtl/uart_row_packet_rx.sv
// uart_row_packet_rx
// Frames the UART byte stream into row packets of the form
// [Y (Y_BYTES, MSB first)] [ROW_BYTES pixel bytes] [STOP_BYTE].
// Pixel bytes go to the frame buffer as they arrive, one cycle after rx_done.
// After each packet one answer byte goes back through the transmitter.
// The block also detects a bad stop byte, an out-of-range Y and an
// inter-byte timeout, and answers ACK_FAIL in each of those cases.
module uart_row_packet_rx #(
    parameter int          ROW_BYTES      = 240,
    parameter int          Y_BYTES        = 2,
    parameter int          HEIGHT         = 480,
    parameter int          ADDR_WIDTH     = 17,
    parameter logic [7:0]  STOP_BYTE      = 8'hDD,
    parameter logic [7:0]  ACK_OK         = 8'hFF,
    parameter logic [7:0]  ACK_FAIL       = 8'h11,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [7:0]            fb_data,
    output logic                  row_done,
    output logic [15:0]           row_y,
    output logic [7:0]            ok_cnt,
    output logic [7:0]            err_cnt
);

    // Derived widths. The wide width WW leaves room for Y * ROW_BYTES
    // and for the HEIGHT comparison without any overflow.
    localparam int YW  = 8 * Y_BYTES;
    localparam int WW  = YW + 32;
    localparam int YCW = $clog2(Y_BYTES + 1);
    localparam int PCW = $clog2(ROW_BYTES + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [YCW-1:0] Y_LAST = YCW'(Y_BYTES - 1);
    localparam logic [PCW-1:0] P_LAST = PCW'(ROW_BYTES - 1);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_Y    = 2'd0,
        WAIT_ROW  = 2'd1,
        WAIT_STOP = 2'd2,
        SEND_ACK  = 2'd3
    } state_t;

    state_t                state_reg,   state_next;
    logic [YW-1:0]         y_acc_reg,   y_acc_next;
    logic [YCW-1:0]        y_cnt_reg,   y_cnt_next;
    logic [PCW-1:0]        pix_cnt_reg, pix_cnt_next;
    logic [TW-1:0]         timer_reg,   timer_next;
    logic [ADDR_WIDTH-1:0] base_reg,    base_next;
    logic                  y_bad_reg,   y_bad_next;
    logic [7:0]            ans_reg,     ans_next;
    logic                  ans_ok_reg,  ans_ok_next;
    logic                  fb_we_reg,   fb_we_next;
    logic [ADDR_WIDTH-1:0] fb_addr_reg, fb_addr_next;
    logic [7:0]            fb_data_reg, fb_data_next;
    logic [15:0]           row_y_reg,   row_y_next;
    logic [7:0]            ok_cnt_reg,  ok_cnt_next;
    logic [7:0]            err_cnt_reg, err_cnt_next;

    logic [YW-1:0]         y_shift;
    logic                  y_out_of_range;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  timing_active;
    logic                  timeout_hit;
    logic                  send_fire;

    // Helper terms shared by the next-state logic.
    always_comb begin
        y_shift        = YW'({y_acc_reg, rx_data});
        y_out_of_range = (WW'(y_shift) >= WW'(HEIGHT));
        row_base       = ADDR_WIDTH'(WW'(y_shift) * WW'(ROW_BYTES));
        // The timer only runs once a packet has actually started.
        timing_active  = ((state_reg == WAIT_Y) && (y_cnt_reg != '0)) ||
                         (state_reg == WAIT_ROW) || (state_reg == WAIT_STOP);
        // A byte on the expiry cycle wins over the timeout.
        timeout_hit    = timing_active && !rx_done && (timer_reg == T_LAST);
        // The start strobe is gated by tx_busy in the same cycle, so it
        // can never overlap a busy transmitter.
        send_fire      = (state_reg == SEND_ACK) && !tx_busy;
    end

    // Next-state and datapath update for the packet FSM.
    always_comb begin
        state_next   = state_reg;
        y_acc_next   = y_acc_reg;
        y_cnt_next   = y_cnt_reg;
        pix_cnt_next = pix_cnt_reg;
        base_next    = base_reg;
        y_bad_next   = y_bad_reg;
        ans_next     = ans_reg;
        ans_ok_next  = ans_ok_reg;
        fb_we_next   = 1'b0;
        fb_addr_next = fb_addr_reg;
        fb_data_next = fb_data_reg;
        row_y_next   = row_y_reg;
        ok_cnt_next  = ok_cnt_reg;
        err_cnt_next = err_cnt_reg;

        if (rx_done || !timing_active) begin
            timer_next = '0;
        end else begin
            timer_next = timer_reg + 1'b1;
        end

        case (state_reg)
            WAIT_Y: begin
                // en only gates the first Y byte; a started packet runs to the end.
                if (rx_done && (en || (y_cnt_reg != '0))) begin
                    y_acc_next = y_shift;
                    if (y_cnt_reg == Y_LAST) begin
                        y_cnt_next   = '0;
                        pix_cnt_next = '0;
                        base_next    = row_base;
                        y_bad_next   = y_out_of_range;
                        state_next   = WAIT_ROW;
                    end else begin
                        y_cnt_next = y_cnt_reg + 1'b1;
                    end
                end else if (timeout_hit) begin
                    ans_next     = ACK_FAIL;
                    ans_ok_next  = 1'b0;
                    y_cnt_next   = '0;
                    pix_cnt_next = '0;
                    state_next   = SEND_ACK;
                end
            end

            WAIT_ROW: begin
                if (rx_done) begin
                    // Rows with an out-of-range Y are consumed but never written.
                    fb_we_next   = !y_bad_reg;
                    fb_addr_next = base_reg + ADDR_WIDTH'(pix_cnt_reg);
                    fb_data_next = rx_data;
                    if (pix_cnt_reg == P_LAST) begin
                        pix_cnt_next = '0;
                        state_next   = WAIT_STOP;
                    end else begin
                        pix_cnt_next = pix_cnt_reg + 1'b1;
                    end
                end else if (timeout_hit) begin
                    ans_next     = ACK_FAIL;
                    ans_ok_next  = 1'b0;
                    pix_cnt_next = '0;
                    state_next   = SEND_ACK;
                end
            end

            WAIT_STOP: begin
                if (rx_done) begin
                    if ((rx_data == STOP_BYTE) && !y_bad_reg) begin
                        ans_next    = ACK_OK;
                        ans_ok_next = 1'b1;
                    end else begin
                        ans_next    = ACK_FAIL;
                        ans_ok_next = 1'b0;
                    end
                    state_next = SEND_ACK;
                end else if (timeout_hit) begin
                    ans_next    = ACK_FAIL;
                    ans_ok_next = 1'b0;
                    state_next  = SEND_ACK;
                end
            end

            SEND_ACK: begin
                // Incoming bytes are dropped here; only tx_busy matters.
                if (send_fire) begin
                    y_cnt_next   = '0;
                    pix_cnt_next = '0;
                    state_next   = WAIT_Y;
                    if (ans_ok_reg) begin
                        row_y_next = 16'(y_acc_reg);
                        if (ok_cnt_reg != 8'hFF) begin
                            ok_cnt_next = ok_cnt_reg + 8'd1;
                        end
                    end else begin
                        if (err_cnt_reg != 8'hFF) begin
                            err_cnt_next = err_cnt_reg + 8'd1;
                        end
                    end
                end
            end

            default: begin
                state_next = WAIT_Y;
            end
        endcase
    end

    // State register; a reset aborts any packet without sending an answer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= WAIT_Y;
            y_acc_reg   <= '0;
            y_cnt_reg   <= '0;
            pix_cnt_reg <= '0;
            timer_reg   <= '0;
            base_reg    <= '0;
            y_bad_reg   <= 1'b0;
            ans_reg     <= '0;
            ans_ok_reg  <= 1'b0;
            fb_we_reg   <= 1'b0;
            fb_addr_reg <= '0;
            fb_data_reg <= '0;
            row_y_reg   <= '0;
            ok_cnt_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            y_acc_reg   <= y_acc_next;
            y_cnt_reg   <= y_cnt_next;
            pix_cnt_reg <= pix_cnt_next;
            timer_reg   <= timer_next;
            base_reg    <= base_next;
            y_bad_reg   <= y_bad_next;
            ans_reg     <= ans_next;
            ans_ok_reg  <= ans_ok_next;
            fb_we_reg   <= fb_we_next;
            fb_addr_reg <= fb_addr_next;
            fb_data_reg <= fb_data_next;
            row_y_reg   <= row_y_next;
            ok_cnt_reg  <= ok_cnt_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // Output drive: frame-buffer port is registered, answer strobes are gated.
    always_comb begin
        tx_start = send_fire;
        tx_data  = ans_reg;
        row_done = send_fire && ans_ok_reg;
        fb_we    = fb_we_reg;
        fb_addr  = fb_addr_reg;
        fb_data  = fb_data_reg;
        row_y    = row_y_reg;
        ok_cnt   = ok_cnt_reg;
        err_cnt  = err_cnt_reg;
    end

endmodule

// File: tb/tb_uart_row_packet_rx.sv
// Testbench for uart_row_packet_rx: a scoreboard of expected frame-buffer
// writes and answer bytes, filled by the stimulus and drained by a monitor.
module tb_uart_row_packet_rx;

    localparam int ROW = 240;
    localparam int YB  = 2;
    localparam int H   = 480;
    localparam int AW  = 17;
    localparam int T   = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          row_done;
    logic [15:0]   row_y;
    logic [7:0]    ok_cnt;
    logic [7:0]    err_cnt;

    uart_row_packet_rx #(
        .ROW_BYTES(ROW), .Y_BYTES(YB), .HEIGHT(H), .ADDR_WIDTH(AW),
        .STOP_BYTE(8'hDD), .ACK_OK(8'hFF), .ACK_FAIL(8'h11),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .row_done(row_done), .row_y(row_y),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int data; int ok; int cyc; } ans_t;
    wr_t  wr_q[$];
    ans_t ans_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int exp_ok = 0;
    int exp_err = 0;
    int exp_row_y = 0;
    int last_rx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Monitor: samples just after each falling edge and drains the scoreboard.
    initial begin
        wr_t  w;
        ans_t a;
        forever begin
            @(negedge clk);
            #1;
            if (fb_we) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(fb_we), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_addr", 32'(fb_addr), w.addr);
                    check("wr_data", 32'(fb_data), w.data);
                    check("wr_cycle", cyc, w.cyc);
                end
            end
            if (tx_start) begin
                check("start_while_busy", 32'(tx_busy), 32'd0);
                if (ans_q.size() == 0) begin
                    check("ans_unexpected", 32'(tx_start), 32'd0);
                end else begin
                    a = ans_q.pop_front();
                    check("ans_data", 32'(tx_data), a.data);
                    check("ans_row_done", 32'(row_done), a.ok);
                    if (a.cyc >= 0) check("ans_cycle", cyc, a.cyc);
                end
            end else if (row_done) begin
                check("row_done_stray", 32'(row_done), 32'd0);
            end
        end
    end

    // One byte strobe; called on a falling edge, returns on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        last_rx = cyc + 1;
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_y(input int y);
        for (int k = YB - 1; k >= 0; k--) send_byte(8'(y >> (8 * k)));
    endtask

    // Pixel bytes; byte late_idx is held back to land exactly on timer expiry.
    task automatic send_pixels(input int y, input int n, input int late_idx);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i == late_idx) begin
                while (cyc + 1 < last_rx + T) @(negedge clk);
            end
            if (y < H) wr_q.push_back('{y * ROW + i, int'(d), cyc + 1});
            send_byte(d);
        end
    endtask

    task automatic push_ans(input int ok, input int y, input int c);
        ans_q.push_back('{(ok != 0) ? 255 : 17, ok, c});
        if (ok != 0) begin
            exp_ok++;
            exp_row_y = y;
        end else begin
            exp_err++;
        end
    endtask

    task automatic wait_ans(input string tag);
        int n = 0;
        while (ans_q.size() != 0 && n < 4 * T) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ans_wait"}, ans_q.size(), 0);
        repeat (2) @(negedge clk);
        check({tag, "_ok_cnt"}, 32'(ok_cnt), exp_ok);
        check({tag, "_err_cnt"}, 32'(err_cnt), exp_err);
        check({tag, "_row_y"}, 32'(row_y), exp_row_y);
        check({tag, "_wr_left"}, wr_q.size(), 0);
        $display("packet %s: ok_cnt=%0d err_cnt=%0d row_y=%0d", tag, ok_cnt, err_cnt, row_y);
    endtask

    task automatic full_packet(input int y, input logic [7:0] stop, input int late_idx, input string tag);
        send_y(y);
        send_pixels(y, ROW, late_idx);
        push_ans(((y < H) && (stop == 8'hDD)) ? 1 : 0, y, cyc + 1);
        send_byte(stop);
        wait_ans(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 0);
        check({tag, "_tx_data"}, 32'(tx_data), 0);
        check({tag, "_fb_we"}, 32'(fb_we), 0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 0);
        check({tag, "_fb_data"}, 32'(fb_data), 0);
        check({tag, "_row_done"}, 32'(row_done), 0);
        check({tag, "_row_y"}, 32'(row_y), 0);
        check({tag, "_ok_cnt"}, 32'(ok_cnt), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        full_packet(0,   8'hDD, -1, "good_y0");
        full_packet(479, 8'hDD, -1, "row479");
        full_packet(480, 8'hDD, -1, "y480_range");
        full_packet(5,   8'hDC, -1, "bad_stop");

        // Silence mid-row: answer arrives exactly T cycles after the last byte.
        send_y(3);
        send_pixels(3, 100, -1);
        push_ans(0, 3, last_rx + T);
        wait_ans("timeout");
        full_packet(4, 8'hDD, -1, "resync");

        // Pixel 17 lands on the expiry cycle and must keep the packet alive.
        full_packet(6, 8'hDD, 17, "edge_expiry");

        // Busy transmitter across the stop byte; bytes during SEND_ACK are dropped.
        tx_busy = 1'b1;
        send_y(10);
        send_pixels(10, ROW, -1);
        send_byte(8'hDD);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h5A);
        send_byte(8'hDD);
        repeat (5) @(negedge clk);
        push_ans(1, 10, cyc);
        tx_busy = 1'b0;
        wait_ans("busy_hold");
        full_packet(11, 8'hDD, -1, "after_busy");

        // One-cycle reset mid-row: outputs clear and no answer follows.
        send_y(7);
        send_pixels(7, 50, -1);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        rst_n = 1'b1;
        exp_ok = 0;
        exp_err = 0;
        exp_row_y = 0;
        repeat (T + 20) @(negedge clk);
        check("mid_reset_no_ans", ans_q.size(), 0);
        full_packet(8, 8'hDD, -1, "post_reset");

        // en low drops idle bytes, but only gates the first Y byte.
        en = 1'b0;
        send_byte(8'h00);
        send_byte(8'h55);
        en = 1'b1;
        send_byte(8'h00);
        en = 1'b0;
        send_byte(8'h0C);
        send_pixels(12, ROW, -1);
        push_ans(1, 12, cyc + 1);
        send_byte(8'hDD);
        wait_ans("en_gate");
        en = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
